// File: rtl/gate_sweep_checker_pkg.sv
// Shared definitions for the gate sweep checker: FSM encoding, err_mask bit
// positions and the settle counter width.
package gate_sweep_checker_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StSettle = 2'd1,
    StCheck  = 2'd2,
    StDone   = 2'd3
  } state_e;

  localparam int unsigned CntW     = 4;
  localparam int unsigned NumGates = 5;

  localparam int unsigned ErrXor  = 4;
  localparam int unsigned ErrNand = 3;
  localparam int unsigned ErrNot  = 2;
  localparam int unsigned ErrOr   = 1;
  localparam int unsigned ErrAnd  = 0;

endpackage

// File: rtl/gate_sweep_checker_ref.sv
// Combinational expected-value generator for the five gates under test,
// packed in err_mask bit order.
module gate_ref_model
  import gate_sweep_checker_pkg::*;
(
  input  logic                a_i,
  input  logic                b_i,
  output logic [NumGates-1:0] exp_o
);

  always_comb begin
    exp_o          = '0;
    exp_o[ErrXor]  = a_i ^ b_i;
    exp_o[ErrNand] = ~(a_i & b_i);
    exp_o[ErrNot]  = ~a_i;
    exp_o[ErrOr]   = a_i | b_i;
    exp_o[ErrAnd]  = a_i & b_i;
  end

endmodule

// File: rtl/gate_sweep_checker.sv
// Sweeps all four {a,b} vectors into an external two-input gate block, lets each
// settle, and records per-gate mismatches and the first failing vector.
module gate_sweep_checker
  import gate_sweep_checker_pkg::*;
#(
  parameter int unsigned SETTLE_CYCLES = 2
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                a_out,
  output logic                b_out,
  input  logic                xor_in,
  input  logic                nand_in,
  input  logic                not_in,
  input  logic                or_in,
  input  logic                and_in,
  output logic                busy,
  output logic                done,
  output logic                pass,
  output logic [NumGates-1:0] err_mask,
  output logic [1:0]          first_fail
);

  localparam logic [CntW-1:0] CntLoad = CntW'(SETTLE_CYCLES - 1);

  state_e              state_q, state_d;
  logic [1:0]          vec_q, vec_d;
  logic [CntW-1:0]     cnt_q, cnt_d;
  logic [NumGates-1:0] err_q, err_d;
  logic                pass_q, pass_d;
  logic [1:0]          ff_q, ff_d;

  logic                driving;
  logic [NumGates-1:0] exp_val;
  logic [NumGates-1:0] obs_val;
  logic [NumGates-1:0] mismatch;

  assign driving = (state_q == StSettle) || (state_q == StCheck);

  gate_ref_model u_ref (
    .a_i   (vec_q[1]),
    .b_i   (vec_q[0]),
    .exp_o (exp_val)
  );

  always_comb begin
    obs_val          = '0;
    obs_val[ErrXor]  = xor_in;
    obs_val[ErrNand] = nand_in;
    obs_val[ErrNot]  = not_in;
    obs_val[ErrOr]   = or_in;
    obs_val[ErrAnd]  = and_in;
  end

  assign mismatch = obs_val ^ exp_val;

  always_comb begin
    state_d = state_q;
    vec_d   = vec_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    pass_d  = pass_q;
    ff_d    = ff_q;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          err_d   = '0;
          pass_d  = 1'b0;
          ff_d    = 2'd0;
          vec_d   = 2'd0;
          cnt_d   = CntLoad;
          state_d = StSettle;
        end
      end
      StSettle: begin
        if (cnt_q == '0) begin
          state_d = StCheck;
        end else begin
          cnt_d = cnt_q - CntW'(1);
        end
      end
      StCheck: begin
        err_d = err_q | mismatch;
        // err_q is cleared on start, so all-zero means no earlier failure
        if ((err_q == '0) && (mismatch != '0)) begin
          ff_d = vec_q;
        end
        if (vec_q == 2'd3) begin
          pass_d  = (err_d == '0);
          state_d = StDone;
        end else begin
          vec_d   = vec_q + 2'd1;
          cnt_d   = CntLoad;
          state_d = StSettle;
        end
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      vec_q   <= 2'd0;
      cnt_q   <= '0;
      err_q   <= '0;
      pass_q  <= 1'b0;
      ff_q    <= 2'd0;
    end else begin
      state_q <= state_d;
      vec_q   <= vec_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      pass_q  <= pass_d;
      ff_q    <= ff_d;
    end
  end

  assign a_out      = driving & vec_q[1];
  assign b_out      = driving & vec_q[0];
  assign busy       = driving;
  assign done       = (state_q == StDone);
  assign pass       = pass_q;
  assign err_mask   = err_q;
  assign first_fail = ff_q;

endmodule

// File: tb/tb_gate_sweep_checker.sv
// Directed bench: a faultable gate model feeds one checker (SETTLE_CYCLES=2) and
// a clean model feeds a second (SETTLE_CYCLES=1); sweep results go through a queue.
module tb_gate_sweep_checker;

  typedef struct packed {
    logic       ok;
    logic [4:0] mask;
    logic [1:0] ff;
  } exp_t;

  logic clk;
  logic rst_n;
  logic start, start1;
  logic fx, fn;

  logic       a0, b0, busy0, done0, pass0;
  logic [4:0] mask0;
  logic [1:0] ff0;
  logic       a1, b1, busy1, done1, pass1;
  logic [4:0] mask1;
  logic [1:0] ff1;

  logic xor0, nand0, not0, or0, and0;

  int   n_cmp;
  int   n_mis;
  exp_t sb[$];

  assign xor0  = fx ? 1'b0 : (a0 ^ b0);
  assign nand0 = ~(a0 & b0);
  assign not0  = fn ? a0 : ~a0;
  assign or0   = a0 | b0;
  assign and0  = a0 & b0;

  gate_sweep_checker #(.SETTLE_CYCLES(2)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .a_out      (a0),
    .b_out      (b0),
    .xor_in     (xor0),
    .nand_in    (nand0),
    .not_in     (not0),
    .or_in      (or0),
    .and_in     (and0),
    .busy       (busy0),
    .done       (done0),
    .pass       (pass0),
    .err_mask   (mask0),
    .first_fail (ff0)
  );

  gate_sweep_checker #(.SETTLE_CYCLES(1)) dut1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start1),
    .a_out      (a1),
    .b_out      (b1),
    .xor_in     (a1 ^ b1),
    .nand_in    (~(a1 & b1)),
    .not_in     (~a1),
    .or_in      (a1 | b1),
    .and_in     (a1 & b1),
    .busy       (busy1),
    .done       (done1),
    .pass       (pass1),
    .err_mask   (mask1),
    .first_fail (ff1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] expv);
    n_cmp++;
    assert (obs === expv)
    else begin
      n_mis++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  // Cycle k is the interval after the k-1'th edge counted from the start-sampling edge.
  task automatic sweep(input bit inst, input int s, input exp_t e, input bit repulse,
                       input bit hold);
    int         n;
    logic [1:0] v;
    logic       oa, ob, obusy, odone, opass;
    logic [4:0] omask;
    logic [1:0] off;
    exp_t       x;
    n = 4 * (s + 1) + 1;
    @(negedge clk);
    if (inst) start1 = 1'b1;
    else start = 1'b1;
    sb.push_back(e);
    for (int k = 1; k <= n + 2; k++) begin
      @(negedge clk);
      if (inst) start1 = hold;
      else start = hold || (repulse && (k == 3 || k == 8));
      oa    = inst ? a1    : a0;
      ob    = inst ? b1    : b0;
      obusy = inst ? busy1 : busy0;
      odone = inst ? done1 : done0;
      opass = inst ? pass1 : pass0;
      omask = inst ? mask1 : mask0;
      off   = inst ? ff1   : ff0;
      if (k < n) begin
        v = 2'((k - 1) / (s + 1));
        chk($sformatf("ab_k%0d", k), {14'd0, oa, ob}, {14'd0, v});
      end else begin
        chk($sformatf("ab_idle_k%0d", k), {14'd0, oa, ob}, 16'd0);
      end
      chk($sformatf("busy_k%0d", k), {15'd0, obusy},
          {15'd0, (k < n) || (hold && k == n + 2)});
      chk($sformatf("done_k%0d", k), {15'd0, odone}, {15'd0, k == n});
      if (odone) begin
        if (sb.size() == 0) begin
          chk("sb_unexpected_done", 16'd1, 16'd0);
        end else begin
          x = sb.pop_front();
          chk("pass", {15'd0, opass}, {15'd0, x.ok});
          chk("err_mask", {11'd0, omask}, {11'd0, x.mask});
          chk("first_fail", {14'd0, off}, {14'd0, x.ff});
        end
      end
      if (!hold && k == n + 2) begin
        chk("hold_results", {8'd0, opass, omask, off}, {8'd0, e});
      end
    end
    start  = 1'b0;
    start1 = 1'b0;
    if (!hold) chk("sb_drained", 16'(sb.size()), 16'd0);
  endtask

  initial begin
    n_cmp  = 0;
    n_mis  = 0;
    rst_n  = 1'b0;
    start  = 1'b0;
    start1 = 1'b0;
    fx     = 1'b0;
    fn     = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_outs0", {4'd0, a0, b0, busy0, done0, pass0, mask0, ff0}, 16'd0);
    chk("reset_outs1", {4'd0, a1, b1, busy1, done1, pass1, mask1, ff1}, 16'd0);
    rst_n = 1'b1;
    @(negedge clk);

    sweep(1'b0, 2, '{ok: 1'b1, mask: 5'b00000, ff: 2'b00}, 1'b0, 1'b0);

    fx = 1'b1;
    sweep(1'b0, 2, '{ok: 1'b0, mask: 5'b10000, ff: 2'b01}, 1'b0, 1'b0);
    fx = 1'b0;

    fn = 1'b1;
    sweep(1'b0, 2, '{ok: 1'b0, mask: 5'b00100, ff: 2'b00}, 1'b0, 1'b0);
    fn = 1'b0;

    sweep(1'b0, 2, '{ok: 1'b1, mask: 5'b00000, ff: 2'b00}, 1'b1, 1'b0);

    // Abort a sweep with reset at cycle 6
    fx = 1'b1;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    chk("pre_abort_busy", {15'd0, busy0}, 16'd1);
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("abort_outs", {4'd0, a0, b0, busy0, done0, pass0, mask0, ff0}, 16'd0);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("abort_no_done", {15'd0, done0}, 16'd0);
    end
    rst_n = 1'b1;
    fx    = 1'b0;
    @(negedge clk);
    chk("post_abort_idle", {15'd0, busy0}, 16'd0);
    sweep(1'b0, 2, '{ok: 1'b1, mask: 5'b00000, ff: 2'b00}, 1'b0, 1'b0);

    sweep(1'b1, 1, '{ok: 1'b1, mask: 5'b00000, ff: 2'b00}, 1'b0, 1'b0);

    // Held start re-triggers right after DONE; then abort the second sweep
    sweep(1'b0, 2, '{ok: 1'b1, mask: 5'b00000, ff: 2'b00}, 1'b0, 1'b1);
    rst_n = 1'b0;
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule

// File: doc/gate_sweep_checker.md
GATE_SWEEP_CHECKER -- requirements
Module: gate_sweep_checker

Interface
REQ-001 Parameter SETTLE_CYCLES, default 2, number of cycles the stimulus is held before the response is sampled; legal range 1..15.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  reset, asynchronous, active-low.
REQ-004 start  input  1  request a full sweep; sampled only in IDLE.
REQ-005 a_out, b_out  output  1 each  stimulus driven into the downstream two-input gate block.
REQ-006 xor_in, nand_in, not_in, or_in, and_in  input  1 each  gate-block responses under test.
REQ-007 busy  output  1  high from the cycle after an accepted start until done is asserted.
REQ-008 done  output  1  one-cycle pulse on sweep completion.
REQ-009 pass  output  1  1 when no mismatch occurred in the last sweep.
REQ-010 err_mask  output  5  sticky per-gate mismatch flags: [4]xor [3]nand [2]not [1]or [0]and.
REQ-011 first_fail  output  2  vector index {a,b} of the first mismatching vector; 0 when pass=1.

Function
REQ-012 FSM states IDLE, SETTLE, CHECK, DONE; state, vector index vec[1:0] and settle counter are registered.
REQ-013 IDLE: when start=1, clear err_mask, pass and first_fail, load vec=0, load the counter with SETTLE_CYCLES-1, and go to SETTLE.
REQ-014 a_out=vec[1] and b_out=vec[0] in SETTLE and CHECK; both are 0 in IDLE and DONE.
REQ-015 SETTLE: decrement the counter each cycle; on the cycle the counter is 0, go to CHECK.
REQ-016 CHECK (one cycle): compare each input with the expected value (xor=a^b, nand=~(a&b), not=~a, or=a|b, and=a&b) and OR the mismatches into err_mask.
REQ-017 CHECK: on the first mismatch of the sweep, capture first_fail=vec; later mismatches do not overwrite it.
REQ-018 CHECK exit: if vec=3, go to DONE; otherwise increment vec, reload the counter, and go to SETTLE.
REQ-019 Each vector occupies SETTLE_CYCLES+1 cycles; done rises exactly 4*(SETTLE_CYCLES+1)+1 cycles after the start-sampling edge (13 cycles for the default).
REQ-020 DONE (one cycle): done=1, pass=(err_mask==0 including the final CHECK result), busy=0, then return to IDLE.
REQ-021 pass, err_mask and first_fail hold their values from DONE until the next accepted start.
REQ-022 start is ignored in SETTLE, CHECK and DONE; no queuing.
REQ-023 A start that is high in IDLE while continuously held re-triggers a new sweep on the cycle after DONE.

Reset
REQ-024 While rst_n=0, the block is in IDLE with vec=0 and counter=0.
REQ-025 While rst_n=0, a_out=0, b_out=0, busy=0, done=0, pass=0, err_mask=0, first_fail=0.
REQ-026 Reset asserted mid-sweep aborts the sweep immediately without a done pulse; the first start after release begins a fresh sweep.

Structure
REQ-027 A shared package holds: the state encoding, the err_mask bit-index constants, and the SETTLE counter width (4).
REQ-028 One sub-module, gate_ref_model, is natural: a combinational expected-value generator for the five gates from (a, b).
REQ-029 The FSM, counter and scoreboard registers are in gate_sweep_checker.

Verification
REQ-030 Correct gate model connected, SETTLE_CYCLES=2, start pulse at cycle 0 -> busy high cycles 1-12, done at cycle 13, pass=1, err_mask=00000.
REQ-031 xor_in tied to 0 -> pass=0, err_mask=10000, first_fail=01.
REQ-032 not_in wired to a instead of ~a -> err_mask=00100, first_fail=00.
REQ-033 start re-pulsed at cycles 3 and 8 -> ignored; exactly one done, at cycle 13.
REQ-034 rst_n low at cycle 6 of a sweep -> all outputs 0 immediately, no done; after release, start -> full sweep completes normally.
REQ-035 SETTLE_CYCLES=1 with a correct model -> done at cycle 9; a_out/b_out step through 00, 01, 10, 11 every 2 cycles.
